led_display_row_streamer: RTL

LED_DISPLAY_ROW_STREAMER -- requirements
Module: led_display_row_streamer

---
 rtl/led_display_row_streamer_if.sv | 37 +++
 rtl/led_display_row_streamer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/led_display_row_streamer_if.sv
// Frame-buffer read port and row hand-off bundle between the
// streamer (master) and its memory/column-shifter neighbours (slave).
interface led_display_row_streamer_if #(
   parameter int ADDR_W = 4,
   parameter int COL_W  = 32
) ();
   logic              fb_rd_en_out;
   logic [ADDR_W-1:0] fb_rd_addr_out;
   logic [COL_W-1:0]  fb_top_data_in;
   logic [COL_W-1:0]  fb_bot_data_in;
   logic              row_valid_out;
   logic [COL_W-1:0]  row_top_out;
   logic [COL_W-1:0]  row_bot_out;
   logic              row_ready_in;

   modport master (
      output fb_rd_en_out,
      output fb_rd_addr_out,
      input  fb_top_data_in,
      input  fb_bot_data_in,
      output row_valid_out,
      output row_top_out,
      output row_bot_out,
      input  row_ready_in
   );

   modport slave (
      input  fb_rd_en_out,
      input  fb_rd_addr_out,
      output fb_top_data_in,
      output fb_bot_data_in,
      input  row_valid_out,
      input  row_top_out,
      input  row_bot_out,
      output row_ready_in
   );
endinterface

// File: rtl/led_display_row_streamer.sv
// Scans a HUB75-style panel one row pair at a time: fetch, hand the
// row to the column shifter, latch it, then light it for a fixed time.
module led_display_row_streamer #(
   parameter int NUM_ROW_PAIRS  = 16,
   parameter int ADDR_W         = 4,
   parameter int DISPLAY_CYCLES = 256,
   parameter int COL_W          = 32
) (
   input  logic                       clk_in,
   input  logic                       reset_in,
   input  logic                       enable_in,
   led_display_row_streamer_if.master bus,
   output logic [ADDR_W-1:0]          row_addr_out,
   output logic                       latch_out,
   output logic                       oe_n_out,
   output logic                       frame_done_out,
   output logic                       busy_out
);

   localparam int CNT_W =
      (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DISP_LOAD =
      CNT_W'(DISPLAY_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW =
      ADDR_W'(NUM_ROW_PAIRS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READ    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_SEND    = 3'd4;
   localparam logic [2:0] S_SHIFT   = 3'd5;
   localparam logic [2:0] S_LATCH   = 3'd6;
   localparam logic [2:0] S_DISPLAY = 3'd7;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_row;
   logic [ADDR_W-1:0] r_row_addr;
   logic [CNT_W-1:0]  r_disp_cnt;
   logic [COL_W-1:0]  r_top;
   logic [COL_W-1:0]  r_bot;
   logic              r_shift_first;
   logic              r_frame_done;
   logic              w_disp_end;

   assign w_disp_end = (r_disp_cnt == '0);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state       <= S_IDLE;
         r_row         <= '0;
         r_row_addr    <= '0;
         r_disp_cnt    <= '0;
         r_top         <= '0;
         r_bot         <= '0;
         r_shift_first <= 1'b0;
         r_frame_done  <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_row <= '0;
               if (enable_in) r_state <= S_READ;
            end
            S_READ: r_state <= S_CAPTURE;
            S_CAPTURE: begin
               r_top   <= bus.fb_top_data_in;
               r_bot   <= bus.fb_bot_data_in;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.row_ready_in) r_state <= S_SEND;
            end
            S_SEND: begin
               r_shift_first <= 1'b1;
               r_state       <= S_SHIFT;
            end
            // Shifter ready may still be stale right after SEND.
            S_SHIFT: begin
               if (r_shift_first) begin
                  r_shift_first <= 1'b0;
               end else if (bus.row_ready_in) begin
                  r_row_addr <= r_row;
                  r_state    <= S_LATCH;
               end
            end
            S_LATCH: begin
               r_disp_cnt <= DISP_LOAD;
               r_state    <= S_DISPLAY;
            end
            S_DISPLAY: begin
               if (w_disp_end) begin
                  if (r_row == LAST_ROW) begin
                     r_frame_done <= 1'b1;
                     r_row        <= '0;
                  end else begin
                     r_row <= r_row + ADDR_W'(1);
                  end
                  if (enable_in) begin
                     r_state <= S_READ;
                  end else begin
                     r_row   <= '0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_disp_cnt <= r_disp_cnt - CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.fb_rd_en_out   = (r_state == S_READ);
   assign bus.fb_rd_addr_out = r_row;
   assign bus.row_valid_out  = (r_state == S_SEND);
   assign bus.row_top_out    = r_top;
   assign bus.row_bot_out    = r_bot;
   assign row_addr_out       = r_row_addr;
   assign latch_out          = (r_state == S_LATCH);
   assign oe_n_out           = (r_state != S_DISPLAY);
   assign frame_done_out     = r_frame_done;
   assign busy_out           = (r_state != S_IDLE);

endmodule
